regfile_wport_arbiter: RTL and testbench

//  Shares the single write port of the 8x16b register file, built from Register_16b_RTL entries, between two writeback requesters.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/Register_16b_RTL.sv | 20 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/regfile_wport_arbiter.sv | 80 ++++++++
 tb/tb_regfile_wport_arbiter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-port slice.
package regfile_pkg;
  localparam int NREGS = 8;
  localparam int RF_AW = $clog2(NREGS);
  localparam int DW    = 16;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [DW-1:0]    rf_data_t;
endpackage

// File: rtl/Register_16b_RTL.sv
// 16-bit register-file entry with load enable; holds its value when en=0.
module Register_16b_RTL
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     en,
  input  rf_data_t d,
  output rf_data_t q
);

  rf_data_t q_q;

  // Load on enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (en) q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a conflict
// the pointer decides, and after each grant the pointer moves to the loser.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] val,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant decode from val and pointer only; nothing granted while disabled or in reset.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en && !rst) begin
      unique case (val)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0])      ptr_d = 1'b1;
    else if (gnt[1]) ptr_d = 1'b0;
  end

  // Pointer register; moves only when a grant is issued.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between ALU writeback (req0) and the
// multicycle unit writeback (req1). One registered write stage drives the
// port; writes to x0 consume a grant but never assert rf_wen. The in-flight
// write is exposed combinationally for read-stage forwarding.
module regfile_wport_arbiter
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req0_val,
  output logic     req0_rdy,
  input  rf_addr_t req0_addr,
  input  rf_data_t req0_data,
  input  logic     req1_val,
  output logic     req1_rdy,
  input  rf_addr_t req1_addr,
  input  rf_data_t req1_data,
  input  logic     rf_stall,
  output logic     rf_wen,
  output rf_addr_t rf_waddr,
  output rf_data_t rf_wdata,
  input  rf_addr_t byp_raddr,
  output logic     byp_hit,
  output rf_data_t byp_data
);

  logic [1:0] gnt;
  logic       xfer;
  logic       stage_en;
  rf_addr_t   sel_addr;
  rf_data_t   sel_data;
  rf_data_t   wdata_d;
  logic       wen_d;
  logic       wen_q;
  rf_addr_t   waddr_d;
  rf_addr_t   waddr_q;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .val ({req1_val, req0_val}),
    .en  (~rf_stall),
    .gnt (gnt)
  );

  assign req0_rdy = gnt[0];
  assign req1_rdy = gnt[1];
  // gnt is only ever raised for a valid requester, so any grant is a transfer.
  assign xfer     = |gnt;
  assign stage_en = xfer | rst;

  // Select the winning request and form the next write-stage contents.
  always_comb begin
    sel_addr = gnt[1] ? req1_addr : req0_addr;
    sel_data = gnt[1] ? req1_data : req0_data;
    wen_d    = !rst && xfer && (sel_addr != '0);
    waddr_d  = rst ? '0 : sel_addr;
    wdata_d  = rst ? '0 : sel_data;
  end

  // Write stage boundary: wen refreshes every cycle, waddr loads on transfer or reset.
  always_ff @(posedge clk) begin
    if (rst) wen_q <= 1'b0;
    else     wen_q <= wen_d;
    if (stage_en) waddr_q <= waddr_d;
  end

  Register_16b_RTL u_wdata_reg (
    .clk (clk),
    .en  (stage_en),
    .d   (wdata_d),
    .q   (rf_wdata)
  );

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign byp_hit  = wen_q && (waddr_q == byp_raddr);
  assign byp_data = rf_wdata;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed plus short random bench for regfile_wport_arbiter with a write scoreboard.
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_val, req1_val, rf_stall;
  logic        req0_rdy, req1_rdy;
  logic [2:0]  req0_addr, req1_addr, byp_raddr, rf_waddr;
  logic [15:0] req0_data, req1_data, rf_wdata, byp_data;
  logic        rf_wen, byp_hit;

  typedef struct packed {
    logic        wen;
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         sb_q[$];
  wr_t         last_exp;
  int          vectors = 0;
  int          miscompares = 0;
  logic        m_ptr;
  logic [2:0]  m_waddr;
  logic [15:0] m_wdata;

  regfile_wport_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0_val  (req0_val),
    .req0_rdy  (req0_rdy),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req1_val  (req1_val),
    .req1_rdy  (req1_rdy),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .rf_stall  (rf_stall),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .byp_raddr (byp_raddr),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check rdy, push expected write; check port after posedge.
  task automatic step(input logic r, input logic s,
                      input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                      input logic v1, input logic [2:0] a1, input logic [15:0] d1,
                      input logic [2:0] br);
    logic g0, g1, hit;
    wr_t  e;
    @(negedge clk);
    rst = r; rf_stall = s;
    req0_val = v0; req0_addr = a0; req0_data = d0;
    req1_val = v1; req1_addr = a1; req1_data = d1;
    byp_raddr = br;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!r && !s) begin
      if (v0 && (!v1 || !m_ptr)) g0 = 1'b1;
      else if (v1)               g1 = 1'b1;
    end
    check("req0_rdy", {15'd0, req0_rdy}, {15'd0, g0});
    check("req1_rdy", {15'd0, req1_rdy}, {15'd0, g1});
    if (r) begin
      m_ptr = 1'b0; m_waddr = 3'd0; m_wdata = 16'd0;
      e.wen = 1'b0;
    end else if (g0) begin
      m_ptr = 1'b1; m_waddr = a0; m_wdata = d0;
      e.wen = (a0 != 3'd0);
    end else if (g1) begin
      m_ptr = 1'b0; m_waddr = a1; m_wdata = d1;
      e.wen = (a1 != 3'd0);
    end else begin
      e.wen = 1'b0;
    end
    e.addr = m_waddr;
    e.data = m_wdata;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    last_exp = e;
    check("rf_wen",   {15'd0, rf_wen}, {15'd0, e.wen});
    check("rf_waddr", {13'd0, rf_waddr}, {13'd0, e.addr});
    check("rf_wdata", rf_wdata, e.data);
    hit = e.wen && (e.addr == br);
    check("byp_hit", {15'd0, byp_hit}, {15'd0, hit});
    if (hit) check("byp_data", byp_data, e.data);
  endtask

  // Re-probe the bypass against the write currently on the port.
  task automatic probe(input logic [2:0] br);
    logic hit;
    byp_raddr = br;
    #1;
    hit = last_exp.wen && (last_exp.addr == br);
    check("byp_hit_probe", {15'd0, byp_hit}, {15'd0, hit});
    if (hit) check("byp_data_probe", byp_data, last_exp.data);
  endtask

  initial begin
    rst = 1'b1; rf_stall = 1'b0;
    req0_val = 1'b0; req0_addr = 3'd0; req0_data = 16'd0;
    req1_val = 1'b0; req1_addr = 3'd0; req1_data = 16'd0;
    byp_raddr = 3'd0;
    m_ptr = 1'b0; m_waddr = 3'd0; m_wdata = 16'd0;

    // Reset with both requesters asking: rdy must stay low.
    step(1, 0, 1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 3'd0);
    step(1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 3'd0);
    step(0, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 3'd0);

    // Single write from req0, then one from req1 to bring ptr back to 0.
    step(0, 0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 3'd3);
    step(0, 0, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h6666, 3'd0);

    // Four cycles of conflict: grants alternate 0,1,0,1 with no bubble.
    step(0, 0, 1, 3'd1, 16'hA001, 1, 3'd2, 16'hB001, 3'd1);
    step(0, 0, 1, 3'd1, 16'hA002, 1, 3'd2, 16'hB001, 3'd2);
    step(0, 0, 1, 3'd1, 16'hA002, 1, 3'd2, 16'hB002, 3'd1);
    step(0, 0, 1, 3'd1, 16'hA003, 1, 3'd2, 16'hB002, 3'd2);

    // req1 to x0: granted, no write enable, ptr flips back to req0.
    step(0, 0, 0, 3'd0, 16'h0000, 1, 3'd0, 16'hBEEF, 3'd0);
    step(0, 0, 1, 3'd4, 16'h4444, 1, 3'd7, 16'h7777, 3'd4);

    // Stall with both valid: no grant, then ptr-selected req1 wins.
    step(0, 1, 1, 3'd4, 16'h4445, 1, 3'd7, 16'h7777, 3'd0);
    step(0, 1, 1, 3'd4, 16'h4445, 1, 3'd7, 16'h7777, 3'd0);
    step(0, 0, 1, 3'd4, 16'h4445, 1, 3'd7, 16'h7777, 3'd7);
    step(0, 0, 1, 3'd4, 16'h4445, 0, 3'd0, 16'h0000, 3'd4);

    // Bypass against an in-flight write to r5.
    step(0, 0, 1, 3'd5, 16'hC0DE, 0, 3'd0, 16'h0000, 3'd5);
    probe(3'd4);
    probe(3'd5);

    // Reset the cycle after a grant drops the write and clears ptr.
    step(0, 0, 0, 3'd0, 16'h0000, 1, 3'd2, 16'hDEAD, 3'd2);
    step(1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 3'd2);
    step(0, 0, 1, 3'd3, 16'h3333, 1, 3'd6, 16'h6667, 3'd3);

    // Short random traffic against the model.
    for (int i = 0; i < 30; i++) begin
      step(1'b0, ($urandom_range(0, 3) == 0),
           1'(($urandom & 1)), 3'($urandom_range(0, 7)), 16'($urandom),
           1'(($urandom & 1)), 3'($urandom_range(0, 7)), 16'($urandom),
           3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
